// File: rtl/wb_pkg.sv
// wb_pkg: shared types and decode helpers for the writeback reorder buffer.
// Entry payload fields are sized to the widest supported configuration;
// the top module uses only the low DATA_WIDTH / ADDRESS_BITS bits.
package wb_pkg;

    localparam int WB_MAX_DATA_W = 64;
    localparam int WB_MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'b00,
        PC_SEL_BRANCH = 2'b01,
        PC_SEL_JAL    = 2'b10,
        PC_SEL_JALR   = 2'b11
    } pc_sel_e;

    typedef struct packed {
        logic                     done;
        logic                     live;
        logic                     op_write;
        logic [4:0]               op_reg;
        logic [WB_MAX_DATA_W-1:0] result;
        pc_sel_e                  pc_select;
        logic [WB_MAX_ADDR_W-1:0] target;
        logic                     branch;
    } rob_entry_t;

    // True when retiring this control transfer must redirect fetch.
    function automatic logic redirect_taken(input pc_sel_e sel, input logic branch);
        case (sel)
            PC_SEL_SEQ:    redirect_taken = 1'b0;
            PC_SEL_BRANCH: redirect_taken = branch;
            PC_SEL_JAL:    redirect_taken = 1'b1;
            PC_SEL_JALR:   redirect_taken = 1'b1;
            default:       redirect_taken = 1'b0;
        endcase
    endfunction

    // True for the PC_select kinds reported to the branch predictor.
    function automatic logic branch_detected(input pc_sel_e sel);
        case (sel)
            PC_SEL_BRANCH: branch_detected = 1'b1;
            PC_SEL_JALR:   branch_detected = 1'b1;
            default:       branch_detected = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_complete_arbiter.sv
// wb_complete_arbiter: for every ROB entry, picks the lowest-numbered
// completion channel strobing that entry and flags any duplicate strobes.
module wb_complete_arbiter #(
    parameter  int NUM_CHANNELS = 2,
    parameter  int ROB_DEPTH    = 4,
    localparam int IDW          = $clog2(ROB_DEPTH),
    localparam int CW           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic [NUM_CHANNELS-1:0]     valid_i,
    input  logic [NUM_CHANNELS*IDW-1:0] id_i,
    output logic [ROB_DEPTH-1:0]        hit_o,
    output logic [ROB_DEPTH*CW-1:0]     chan_o,
    output logic                        dup_o
);

    logic [ROB_DEPTH-1:0]    hit_s;
    logic [ROB_DEPTH*CW-1:0] chan_s;
    logic                    dup_s;

    // Scan channels in ascending order so the lowest index claims each entry.
    always_comb begin
        hit_s  = '0;
        chan_s = '0;
        dup_s  = 1'b0;
        for (int e = 0; e < ROB_DEPTH; e++) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (valid_i[c] && (id_i[c*IDW +: IDW] == IDW'(e))) begin
                    if (hit_s[e]) begin
                        dup_s = 1'b1;
                    end else begin
                        hit_s[e]           = 1'b1;
                        chan_s[e*CW +: CW] = CW'(c);
                    end
                end else begin
                end
            end
        end
    end

    assign hit_o  = hit_s;
    assign chan_o = chan_s;
    assign dup_o  = dup_s;

endmodule

// File: rtl/writeback_rob.sv
// writeback_rob: accepts out-of-order completions on NUM_CHANNELS ports into
// a circular reorder buffer and retires one entry per cycle in allocation
// order. A retiring taken control transfer flushes all younger entries.
// Build option WB_HEAD_BYPASS_EN: a completion aimed at the live, not yet
// done head entry retires at the same edge instead of being buffered first.
module writeback_rob
    import wb_pkg::*;
#(
    parameter  int CORE         = 0,
    parameter  int DATA_WIDTH   = 32,
    parameter  int ADDRESS_BITS = 20,
    parameter  int NUM_CHANNELS = 2,
    parameter  int ROB_DEPTH    = 4,
    localparam int IDW          = $clog2(ROB_DEPTH)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             alloc_valid,
    output logic                             alloc_ready,
    output logic [IDW-1:0]                   alloc_ID,
    input  logic [NUM_CHANNELS-1:0]          complete_valid,
    input  logic [NUM_CHANNELS*IDW-1:0]      complete_ID,
    input  logic [NUM_CHANNELS-1:0]          complete_opWrite,
    input  logic [NUM_CHANNELS*5-1:0]        complete_opReg,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   complete_result,
    input  logic [NUM_CHANNELS*2-1:0]        complete_PC_select,
    input  logic [NUM_CHANNELS*ADDRESS_BITS-1:0] complete_target,
    input  logic [NUM_CHANNELS-1:0]          complete_branch,
    output logic                             write,
    output logic [4:0]                       write_reg,
    output logic [DATA_WIDTH-1:0]            write_data,
    output logic                             valid,
    output logic [IDW-1:0]                   writeback_instruction_ID,
    output logic [1:0]                       PC_select_writeback,
    output logic [ADDRESS_BITS-1:0]          redirect_target,
    output logic                             branch_writeback,
    output logic                             branch_detected_writeback,
    output logic                             flush,
    output logic [IDW:0]                     occupancy,
    output logic                             error
);

    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [IDW:0]            head_q, head_d, tail_q, tail_d;
    logic [IDW-1:0]          head_idx_s, tail_idx_s;
    logic [IDW:0]            occupancy_s;
    rob_entry_t              entries_q [ROB_DEPTH];
    rob_entry_t              entries_d [ROB_DEPTH];
    rob_entry_t              chan_ent_s [NUM_CHANNELS];
    rob_entry_t              head_ent_s, ret_ent_s;
    logic [ROB_DEPTH-1:0]    sel_hit_s;
    logic [ROB_DEPTH*CW-1:0] sel_chan_s;
    logic                    dup_s, retire_s, bypass_s, flush_now_s;
    logic                    alloc_ready_s, err_now_s;

    logic                    valid_q, write_q, flush_q, error_q, branch_q, bdet_q;
    logic [4:0]              write_reg_q;
    logic [DATA_WIDTH-1:0]   write_data_q;
    logic [IDW-1:0]          id_q;
    logic [1:0]              pc_sel_q;
    logic [ADDRESS_BITS-1:0] target_q;

    assign head_idx_s    = head_q[IDW-1:0];
    assign tail_idx_s    = tail_q[IDW-1:0];
    assign occupancy_s   = tail_q - head_q;
    assign alloc_ready_s = (occupancy_s < (IDW+1)'(ROB_DEPTH)) && !flush_now_s;

    wb_complete_arbiter #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .ROB_DEPTH    (ROB_DEPTH)
    ) u_arbiter (
        .valid_i (complete_valid),
        .id_i    (complete_ID),
        .hit_o   (sel_hit_s),
        .chan_o  (sel_chan_s),
        .dup_o   (dup_s)
    );

    // Unpack each completion channel into a ready-to-store done entry.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            chan_ent_s[c]                          = '0;
            chan_ent_s[c].done                     = 1'b1;
            chan_ent_s[c].live                     = 1'b1;
            chan_ent_s[c].op_write                 = complete_opWrite[c];
            chan_ent_s[c].op_reg                   = complete_opReg[c*5 +: 5];
            chan_ent_s[c].result[DATA_WIDTH-1:0]   = complete_result[c*DATA_WIDTH +: DATA_WIDTH];
            chan_ent_s[c].pc_select                = pc_sel_e'(complete_PC_select[c*2 +: 2]);
            chan_ent_s[c].target[ADDRESS_BITS-1:0] = complete_target[c*ADDRESS_BITS +: ADDRESS_BITS];
            chan_ent_s[c].branch                   = complete_branch[c];
        end
    end

`ifdef WB_HEAD_BYPASS_EN
    logic [CW-1:0] head_chan_s;
    assign head_chan_s = sel_chan_s[head_idx_s*CW +: CW];
`endif

    // Choose the entry retiring at this edge and whether it redirects fetch.
    always_comb begin
        head_ent_s = entries_q[head_idx_s];
        bypass_s   = 1'b0;
        if (head_ent_s.live && head_ent_s.done) begin
            retire_s  = 1'b1;
            ret_ent_s = head_ent_s;
`ifdef WB_HEAD_BYPASS_EN
        end else if (head_ent_s.live && sel_hit_s[head_idx_s]) begin
            retire_s  = 1'b1;
            bypass_s  = 1'b1;
            ret_ent_s = chan_ent_s[head_chan_s];
`endif
        end else begin
            retire_s  = 1'b0;
            ret_ent_s = head_ent_s;
        end
        flush_now_s = retire_s && redirect_taken(ret_ent_s.pc_select, ret_ent_s.branch);
    end

    // Next buffer state: a flush wipes everything younger than head, otherwise
    // apply completions, retirement and allocation in that order.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        err_now_s = 1'b0;
        if (flush_now_s) begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                entries_d[e] = '0;
            end
            head_d = head_q + (IDW+1)'(1);
            tail_d = head_q + (IDW+1)'(1);
        end else begin
            err_now_s = dup_s;
            for (int e = 0; e < ROB_DEPTH; e++) begin
                if (!sel_hit_s[e] || (bypass_s && (IDW'(e) == head_idx_s))) begin
                end else if (entries_q[e].live && !entries_q[e].done) begin
                    entries_d[e] = chan_ent_s[sel_chan_s[e*CW +: CW]];
                end else begin
                    err_now_s = 1'b1;
                end
            end
            if (retire_s) begin
                entries_d[head_idx_s] = '0;
                head_d                = head_q + (IDW+1)'(1);
            end else begin
            end
            if (alloc_valid && alloc_ready_s) begin
                entries_d[tail_idx_s]      = '0;
                entries_d[tail_idx_s].live = 1'b1;
                tail_d                     = tail_q + (IDW+1)'(1);
            end else begin
            end
        end
    end

    // Buffer storage and pointers; reset discards every entry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            for (int e = 0; e < ROB_DEPTH; e++) begin
                entries_q[e] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int e = 0; e < ROB_DEPTH; e++) begin
                entries_q[e] <= entries_d[e];
            end
        end
    end

    // Retirement output registers; payload holds when nothing retires.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            write_q      <= 1'b0;
            flush_q      <= 1'b0;
            error_q      <= 1'b0;
            branch_q     <= 1'b0;
            bdet_q       <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= '0;
            id_q         <= '0;
            pc_sel_q     <= 2'b00;
            target_q     <= '0;
        end else begin
            valid_q <= retire_s;
            flush_q <= flush_now_s;
            error_q <= error_q | err_now_s;
            if (retire_s) begin
                write_q      <= ret_ent_s.op_write;
                write_reg_q  <= ret_ent_s.op_reg;
                write_data_q <= ret_ent_s.result[DATA_WIDTH-1:0];
                id_q         <= head_idx_s;
                pc_sel_q     <= ret_ent_s.pc_select;
                target_q     <= ret_ent_s.target[ADDRESS_BITS-1:0];
                branch_q     <= ret_ent_s.branch;
                bdet_q       <= branch_detected(ret_ent_s.pc_select);
            end else begin
                write_q <= 1'b0;
            end
        end
    end

    assign alloc_ready               = alloc_ready_s;
    assign alloc_ID                  = tail_idx_s;
    assign occupancy                 = occupancy_s;
    assign valid                     = valid_q;
    assign write                     = write_q;
    assign write_reg                 = write_reg_q;
    assign write_data                = write_data_q;
    assign writeback_instruction_ID  = id_q;
    assign PC_select_writeback       = pc_sel_q;
    assign redirect_target           = target_q;
    assign branch_writeback          = branch_q;
    assign branch_detected_writeback = bdet_q;
    assign flush                     = flush_q;
    assign error                     = error_q;

endmodule

// File: tb/tb_writeback_rob.sv
// tb_writeback_rob: randomized and directed stimulus against a queue-based
// reference model; expected retirements go to a scoreboard drained by a monitor.
module tb_writeback_rob;

    localparam int DW    = 32;
    localparam int AW    = 20;
    localparam int NC    = 2;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              alloc_valid = 1'b0;
    logic              alloc_ready;
    logic [IDW-1:0]    alloc_ID;
    logic [NC-1:0]     complete_valid = '0;
    logic [NC*IDW-1:0] complete_ID = '0;
    logic [NC-1:0]     complete_opWrite = '0;
    logic [NC*5-1:0]   complete_opReg = '0;
    logic [NC*DW-1:0]  complete_result = '0;
    logic [NC*2-1:0]   complete_PC_select = '0;
    logic [NC*AW-1:0]  complete_target = '0;
    logic [NC-1:0]     complete_branch = '0;
    logic              write, valid, branch_writeback, branch_detected_writeback, flush, error;
    logic [4:0]        write_reg;
    logic [DW-1:0]     write_data;
    logic [IDW-1:0]    writeback_instruction_ID;
    logic [1:0]        PC_select_writeback;
    logic [AW-1:0]     redirect_target;
    logic [IDW:0]      occupancy;

    writeback_rob #(.CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW),
                    .NUM_CHANNELS(NC), .ROB_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_ID(alloc_ID),
        .complete_valid(complete_valid), .complete_ID(complete_ID),
        .complete_opWrite(complete_opWrite), .complete_opReg(complete_opReg),
        .complete_result(complete_result), .complete_PC_select(complete_PC_select),
        .complete_target(complete_target), .complete_branch(complete_branch),
        .write(write), .write_reg(write_reg), .write_data(write_data), .valid(valid),
        .writeback_instruction_ID(writeback_instruction_ID),
        .PC_select_writeback(PC_select_writeback), .redirect_target(redirect_target),
        .branch_writeback(branch_writeback),
        .branch_detected_writeback(branch_detected_writeback),
        .flush(flush), .occupancy(occupancy), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            edge_no;
        bit            wr;
        int            rg;
        logic [DW-1:0] data;
        int            id;
        int            sel;
        logic [AW-1:0] tgt;
        bit            br;
        bit            fl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;

    // Reference model: live IDs in allocation order plus per-ID completion records.
    int   ids[$];
    bit   done_m[DEPTH];
    exp_t rec_m[DEPTH];
    int   tail_m = 0;
    bit   err_m  = 1'b0;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t chan_rec(input int c);
        exp_t r;
        r = '{default: 0};
        r.wr   = complete_opWrite[c];
        r.rg   = int'(complete_opReg[c*5 +: 5]);
        r.data = complete_result[c*DW +: DW];
        r.sel  = int'(complete_PC_select[c*2 +: 2]);
        r.tgt  = complete_target[c*AW +: AW];
        r.br   = complete_branch[c];
        return r;
    endfunction

    function automatic bit is_live(input int id);
        foreach (ids[i]) if (ids[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        ids.delete();
        foreach (done_m[i]) done_m[i] = 1'b0;
        tail_m = 0;
        err_m  = 1'b0;
    endtask

    // One cycle of the reference model, evaluated with this cycle's inputs applied.
    task automatic model_step();
        int   occ, h, id;
        bit   ret, byp, fl;
        bit   seen[DEPTH];
        exp_t r;
        occ = ids.size();
        ret = 1'b0; byp = 1'b0; fl = 1'b0; h = 0;
        r = '{default: 0};
        foreach (seen[i]) seen[i] = 1'b0;
        if (occ > 0) begin
            h = ids[0];
            if (done_m[h]) begin
                ret = 1'b1;
                r   = rec_m[h];
            end
`ifdef WB_HEAD_BYPASS_EN
            else begin
                for (int c = 0; c < NC; c++) begin
                    if (!ret && complete_valid[c] && int'(complete_ID[c*IDW +: IDW]) == h) begin
                        ret = 1'b1; byp = 1'b1; r = chan_rec(c);
                    end
                end
            end
`endif
        end
        if (ret) fl = (r.sel == 2) || (r.sel == 3) || (r.sel == 1 && r.br);
        chk("alloc_ready", alloc_ready, (occ < DEPTH) && !fl);
        chk("alloc_ID", alloc_ID, tail_m);
        chk("occupancy", occupancy, occ);
        chk("error", error, err_m);
        if (ret) begin
            r.edge_no = edge_n + 1;
            r.id      = h;
            r.fl      = fl;
            exp_q.push_back(r);
        end
        if (fl) begin
            ids.delete();
            foreach (done_m[i]) done_m[i] = 1'b0;
            tail_m = (h + 1) % DEPTH;
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (complete_valid[c]) begin
                    id = int'(complete_ID[c*IDW +: IDW]);
                    if (seen[id]) err_m = 1'b1;
                    else begin
                        seen[id] = 1'b1;
                        if (byp && id == h) begin end
                        else if (is_live(id) && !done_m[id]) begin
                            done_m[id] = 1'b1;
                            rec_m[id]  = chan_rec(c);
                        end else err_m = 1'b1;
                    end
                end
            end
            if (ret) begin
                void'(ids.pop_front());
                done_m[h] = 1'b0;
            end
            if (alloc_valid && occ < DEPTH) begin
                ids.push_back(tail_m);
                done_m[tail_m] = 1'b0;
                tail_m = (tail_m + 1) % DEPTH;
            end
        end
    endtask

    // Inputs are already applied at this falling edge; model, then advance one cycle.
    task automatic tick();
        #1;
        if (reset) model_step();
        else model_reset();
        @(negedge clock);
        alloc_valid = 1'b0;
        complete_valid = '0;
    endtask

    task automatic set_comp(input int c, input int id, input bit wr, input int rg,
                            input logic [DW-1:0] res, input int sel,
                            input logic [AW-1:0] tgt, input bit br);
        complete_valid[c]              = 1'b1;
        complete_ID[c*IDW +: IDW]      = id[IDW-1:0];
        complete_opWrite[c]            = wr;
        complete_opReg[c*5 +: 5]       = rg[4:0];
        complete_result[c*DW +: DW]    = res;
        complete_PC_select[c*2 +: 2]   = sel[1:0];
        complete_target[c*AW +: AW]    = tgt;
        complete_branch[c]             = br;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("reset_ctrl_outputs",
            {valid, write, flush, error, branch_writeback, branch_detected_writeback,
             PC_select_writeback, write_reg, writeback_instruction_ID}, 64'd0);
        chk("reset_write_data", write_data, 64'd0);
        chk("reset_redirect_target", redirect_target, 64'd0);
    endtask

    // Scoreboard monitor: every retirement must match the oldest expectation for this edge.
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
            chk("missed_retire_id", 64'hFFFF, exp_q[0].id);
            void'(exp_q.pop_front());
        end
        if (valid === 1'b1) begin
            if (exp_q.size() == 0 || exp_q[0].edge_no != edge_n) begin
                chk("unexpected_retire_id", writeback_instruction_ID, 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_id", writeback_instruction_ID, e.id);
                chk("wb_write", write, e.wr);
                chk("wb_reg", write_reg, e.rg);
                chk("wb_data", write_data, e.data);
                chk("wb_pc_select", PC_select_writeback, e.sel);
                chk("wb_target", redirect_target, e.tgt);
                chk("wb_branch", branch_writeback, e.br);
                chk("wb_branch_detected", branch_detected_writeback, (e.sel == 1) || (e.sel == 3));
                chk("wb_flush", flush, e.fl);
            end
        end else if (valid !== 1'b0) begin
            chk("valid_known", valid, 64'd0);
        end else begin
            chk("flush_without_valid", flush, 64'd0);
        end
    end

    initial begin
        int cand[$];
        int pick, r;
        @(negedge clock);
        do_reset();

        // In-order retirement of out-of-order completions.
        repeat (3) begin alloc_valid = 1'b1; tick(); end
        set_comp(0, 2, 1'b1, 5, 32'd10, 0, 20'h0, 1'b0); tick();
        set_comp(0, 1, 1'b1, 6, 32'd20, 0, 20'h0, 1'b0); tick();
        set_comp(0, 0, 1'b1, 7, 32'd30, 0, 20'h0, 1'b0); tick();
        repeat (4) tick();

        // Full buffer, then one retire frees a slot and alloc_ID wraps.
        do_reset();
        repeat (5) begin alloc_valid = 1'b1; tick(); end
        set_comp(1, 0, 1'b1, 3, 32'hAB, 0, 20'h0, 1'b0); tick();
        alloc_valid = 1'b1; tick();
        alloc_valid = 1'b1; tick();
        repeat (2) tick();

        // JALR at ID 1 flushes younger entries 2 and 3.
        do_reset();
        repeat (4) begin alloc_valid = 1'b1; tick(); end
        set_comp(0, 1, 1'b1, 1, 32'h111, 3, 20'h00400, 1'b0);
        set_comp(1, 0, 1'b1, 2, 32'h222, 0, 20'h0, 1'b0); tick();
        set_comp(0, 2, 1'b1, 3, 32'h333, 0, 20'h0, 1'b0);
        set_comp(1, 3, 1'b1, 4, 32'h444, 1, 20'h00123, 1'b1); tick();
        repeat (4) tick();

        // Head latency, then duplicate completion: channel 0 wins, error sticks.
        do_reset();
        repeat (3) begin alloc_valid = 1'b1; tick(); end
        set_comp(0, 0, 1'b1, 8, 32'h55, 0, 20'h0, 1'b0); tick();
        repeat (2) tick();
        set_comp(0, 1, 1'b0, 9, 32'h66, 1, 20'h00777, 1'b0); tick();
        set_comp(0, 2, 1'b1, 9, 32'd5, 0, 20'h0, 1'b0);
        set_comp(1, 2, 1'b1, 9, 32'd9, 0, 20'h0, 1'b0); tick();
        repeat (4) tick();

        // Randomized traffic with a reset in the middle.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            reset = (k != 300);
            alloc_valid = ($urandom_range(0, 3) != 0);
            cand.delete();
            foreach (ids[i]) if (!done_m[ids[i]]) cand.push_back(ids[i]);
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    pick = -1;
                    if ($urandom_range(0, 39) == 0) pick = $urandom_range(0, DEPTH - 1);
                    else if (cand.size() > 0) begin
                        r = $urandom_range(0, cand.size() - 1);
                        pick = cand[r];
                        cand.delete(r);
                    end
                    if (pick >= 0) begin
                        r = $urandom_range(0, 9);
                        set_comp(c, pick, 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                                 DW'($urandom()), (r < 7) ? 0 : r - 6,
                                 AW'($urandom()), 1'($urandom_range(0, 1)));
                    end
                end
            end
            tick();
        end
        reset = 1'b1;
        repeat (6) tick();
        chk("scoreboard_drained", exp_q.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
